uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync2.sv | 33 +++
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//
// Contents:
//   CLKS_PER_BIT_DEFAULT : default number of clk cycles per serial bit
//   LINE_IDLE            : logic level of an idle serial line (mark = 1)
//   rx_state_t           : receiver FSM states
//
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, the PARITY
// state exists in rx_state_t.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int   CLKS_PER_BIT_DEFAULT = 16;
    localparam logic LINE_IDLE            = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2 -- two-flop synchronizer for an asynchronous serial line.
//
// Ports:
//   clk : rising-edge clock of the receiving domain
//   rst : asynchronous active-high reset; both flops reset to the idle level
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;

    // Resetting to the idle level keeps the receiver from seeing a spurious
    // falling edge as it leaves reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= LINE_IDLE;
            q        <= LINE_IDLE;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- UART receiver: start bit, DATA_BITS data bits (LSB first),
// optional even parity bit, one stop bit.
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (4..65535)
//   DATA_BITS    : data bits per frame (5..8)
//
// Ports:
//   clk        : rising-edge system clock
//   rst        : asynchronous active-high reset
//   serial_in  : asynchronous serial line, idle high
//   data_read  : consumer acknowledge, clears data_valid and overrun
//   data_out   : last received word, bit 0 = first data bit
//   data_valid : data_out holds an unread word
//   frame_err  : stop bit of the last frame was sampled low
//   overrun    : a frame completed while the previous word was unread
//   parity_err : (UART_RX_PARITY_EN only) last frame failed even parity
//
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state and the
// parity_err port.
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam int             BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]  BIT_ONE  = BW'(1);

    logic                 rx_sync;
    logic                 line_prev_reg;
    rx_state_t            state_reg,  state_next;
    logic [CW-1:0]        cnt_reg,    cnt_next;
    logic [BW-1:0]        bit_reg,    bit_next;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;
    logic                 frame_done;
`ifdef UART_RX_PARITY_EN
    logic                 par_reg,    par_next;
`endif

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (rx_sync)
    );

    // State, counters and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            line_prev_reg <= LINE_IDLE;
`ifdef UART_RX_PARITY_EN
            par_reg       <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            line_prev_reg <= rx_sync;
`ifdef UART_RX_PARITY_EN
            par_reg       <= par_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                // Edge, not level: a line still low after a broken frame
                // must go high again before it can start another one.
                if (line_prev_reg && !rx_sync) begin
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == HALF_CNT) begin
                    cnt_next = '0;
                    if (!rx_sync) begin
                        bit_next   = '0;
                        state_next = DATA;
                    end else begin
                        // Start bit gone by mid-bit: treat it as a glitch.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift_reg[DATA_BITS-1:1]};
                    if (bit_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BIT_ONE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next   = '0;
                    par_next   = rx_sync;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (cnt_reg == FULL_CNT) begin
                    cnt_next   = '0;
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result registers. A completed frame always delivers its word, even with
    // a bad stop bit; a read on the completion cycle acknowledges the old
    // word, so the new one stays valid without an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (frame_done) begin
                data_out  <= shift_reg;
                frame_err <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
                parity_err <= (^shift_reg) ^ par_reg;
`endif
            end
            data_valid <= frame_done | (data_valid & ~data_read);
            overrun    <= (overrun & ~data_read)
                        | (frame_done & data_valid & ~data_read);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (default 16 clk/bit, 8 bits).
// Compile with UART_RX_PARITY_EN to exercise the parity variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int NBITS    = DB + PB + 2;
    // Negedge index (from the start-bit edge) just before the result shows.
    localparam int DONE_CYC = 2 + CPB / 2 + (NBITS - 1) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_in;
    logic          data_read;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          overrun;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .data_read  (data_read),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level reference model of the visible receiver state.
    logic [DB-1:0] m_data;
    logic m_valid, m_ferr, m_ovr, m_perr;

    typedef struct {
        int          op;      // 0 = send frame, 1 = data_read pulse
        logic [7:0]  data;
        logic        stop;
        logic        par;
        logic        lat;     // check the completion latency
        logic [7:0]  e_data;
        logic        e_valid;
        logic        e_ferr;
        logic        e_ovr;
        logic        e_perr;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop, input logic par,
                               input logic read_same);
        if (read_same)    m_ovr = 1'b0;
        else if (m_valid) m_ovr = 1'b1;
        m_data  = d[DB-1:0];
        m_valid = 1'b1;
        m_ferr  = !stop;
        m_perr  = (^d[DB-1:0]) ^ par;
    endtask

    task automatic model_read();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data_out"},   32'(data_out),   32'(m_data));
        check({tag, ".data_valid"}, 32'(data_valid), 32'(m_valid));
        check({tag, ".frame_err"},  32'(frame_err),  32'(m_ferr));
        check({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
`ifdef UART_RX_PARITY_EN
        check({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
    endtask

    task automatic idle(input int n, input logic level);
        serial_in = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic read_pulse();
        @(negedge clk) data_read = 1'b1;
        @(negedge clk) data_read = 1'b0;
        model_read();
    endtask

    // Drives one whole frame; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                              input logic lat_chk, input logic rd_done);
        logic [NBITS-1:0] fr;
        fr = '0;
        for (int i = 0; i < DB; i++) fr[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
        fr[DB+1] = par;
`endif
        fr[NBITS-1] = stop;
        for (int c = 0; c < NBITS * CPB; c++) begin
            @(negedge clk);
            if (lat_chk && c == DONE_CYC)
                check("latency.valid_before", 32'(data_valid), 32'(0));
            if (lat_chk && c == DONE_CYC + 1) begin
                check("latency.valid_after", 32'(data_valid), 32'(1));
                check("latency.data",        32'(data_out),   32'(d[DB-1:0]));
                check("latency.frame_err",   32'(frame_err),  32'(!stop));
            end
            if (rd_done) data_read = (c == DONE_CYC);
            serial_in = fr[c / CPB];
        end
        data_read = 1'b0;
        $display("frame 0x%02h stop=%0d par=%0d rd_same=%0d -> data_out=0x%02h valid=%0d ferr=%0d ovr=%0d",
                 d, stop, par, rd_done, data_out, data_valid, frame_err, overrun);
    endtask

    initial begin
        logic [7:0] d;
        logic stop, par, rd_same;

        // Directed table: send/read sequence with hand-derived expectations.
        tbl[0] = '{0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{0, 8'h22, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; serial_in = 1'b1; data_read = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_model("reset");
        rst = 1'b0;
        idle(10, 1'b1);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].op == 0) begin
                send_frame(tbl[i].data, tbl[i].stop, tbl[i].par, tbl[i].lat, 1'b0);
                model_frame(tbl[i].data, tbl[i].stop, tbl[i].par, 1'b0);
                idle(20, 1'b1);
            end else begin
                read_pulse();
                @(negedge clk);
                $display("read -> valid=%0d ovr=%0d", data_valid, overrun);
            end
            check($sformatf("tbl%0d.data_out", i),   32'(data_out),   32'(tbl[i].e_data));
            check($sformatf("tbl%0d.data_valid", i), 32'(data_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d.frame_err", i),  32'(frame_err),  32'(tbl[i].e_ferr));
            check($sformatf("tbl%0d.overrun", i),    32'(overrun),    32'(tbl[i].e_ovr));
`ifdef UART_RX_PARITY_EN
            check($sformatf("tbl%0d.parity_err", i), 32'(parity_err), 32'(tbl[i].e_perr));
`endif
        end

        // Short low pulse in IDLE: no frame, no flag change.
        idle(CPB / 4, 1'b0);
        idle(3 * CPB, 1'b1);
        $display("glitch -> valid=%0d ferr=%0d ovr=%0d", data_valid, frame_err, overrun);
        check_model("glitch");

        // Broken frame leaving the line low: no new frame until it rises.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        read_pulse();
        idle(25 * CPB, 1'b0);
        $display("held low -> valid=%0d", data_valid);
        check_model("held_low");
        idle(20, 1'b1);

        // Completion and data_read on the same cycle.
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        model_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(20, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
        model_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        idle(20, 1'b1);
        check_model("read_same_cycle");

        // Reset in the middle of the data bits of 0xFF.
        idle(CPB, 1'b0);
        idle(3 * CPB, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        $display("reset mid-frame -> data_out=0x%02h valid=%0d", data_out, data_valid);
        check_model("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(20, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        model_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(20, 1'b1);
        check("after_reset.data_out", 32'(data_out), 32'(8'h5A));
        check_model("after_reset");
        read_pulse();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        model_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(20, 1'b1);
        check("parity0.parity_err", 32'(parity_err), 32'(1));
        read_pulse();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        model_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(20, 1'b1);
        check("parity1.parity_err", 32'(parity_err), 32'(0));
        read_pulse();
`endif

        // Randomized frames against the model.
        for (int n = 0; n < 24; n++) begin
            d       = 8'($urandom);
            stop    = ($urandom_range(0, 3) != 0);
            par     = (^d) ^ ($urandom_range(0, 3) == 0);
            rd_same = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 1) read_pulse();
            send_frame(d, stop, par, 1'b0, rd_same);
            model_frame(d, stop, par, rd_same);
            idle(20, 1'b1);
            check_model($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
